adr_writeback: RTL
==================

# adr_writeback

Write-side driver for the register file write port: merges ALU results and load-unit results into the single write port, one write per cycle. ALU results have fixed priority; load results are accepted by valid/ready handshake and buffered in a small FIFO when the port is busy. Writes to x0 are discarded. The committed write is also exported as a forwarding source, because a register-file read issued in the same cycle returns the old value.

## Interface
- XLEN, 32, data width.
- REG_ADDR_LEN, 5, register index width.
- LQ_DEPTH, 2, load-result FIFO depth; power of two, at least 2.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- alu_valid_i  in  1  ALU result present this cycle; no backpressure.
- alu_rd_i  in  REG_ADDR_LEN  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- load_valid_i  in  1  load result offered.
- load_ready_o  out  1  load result accepted when high with load_valid_i.
- load_rd_i  in  REG_ADDR_LEN  load destination register.
- load_data_i  in  XLEN  load data.
- wb_valid_o  out  1  a real write is on the port this cycle.
- wb_addr_o  out  REG_ADDR_LEN  to the register file write address.
- wb_data_o  out  XLEN  to the register file write data.
- pending_o  out  32  bit i set while any FIFO entry targets register i.
- lq_count_o  out  clog2(LQ_DEPTH)+1  FIFO occupancy.

## Operation
- The register file writes every cycle. When idle, the block drives wb_addr_o=0 and wb_data_o=0, so the idle write lands harmlessly on x0.
- A result with rd=0 is dropped.
  - An ALU result to x0 counts as no ALU result for arbitration.
  - A load to x0 is still handshaken (consumed) but never written and never enqueued.
- Source select, evaluated each cycle, first match wins:
  1. ALU, if alu_valid_i and alu_rd_i≠0.
  2. FIFO head, if the FIFO is non-empty.
  3. Cut-through load, if the load handshake fires, load_rd_i≠0 and the FIFO is empty. The load is written directly and not enqueued.
  4. Otherwise idle.
- Enqueue: the handshake fires, load_rd_i≠0, and the load is not taken by cut-through.
- Dequeue: the head is selected.
- Enqueue and dequeue may happen in the same cycle; occupancy is then unchanged.
- The FIFO is a circular buffer with wrapping read/write pointers and an occupancy counter. Order among loads is strictly preserved.
- load_ready_o = (lq_count_o < LQ_DEPTH) and not reset.
  - It is computed from the registered count only; a same-cycle dequeue does not raise ready.
  - Valid/ready rule: the producer holds load_valid_i and load data stable until ready.
- pending_o is combinational over the valid FIFO entries only. The entry in the wb output register is not included.
- Result ordering for the same rd:
  - An ALU write to a register with a pending load is written first; the load later overwrites it.
  - Upstream issue logic uses pending_o to avoid this WAW case.

## Timing
- Output registers: wb_valid_o, wb_addr_o and wb_data_o are registered.
  - A source selected in cycle N appears on wb_* in cycle N+1.
  - The register file captures it at the end of cycle N+1.
  - A read issued in cycle N+2 or later sees the new value.
- Forwarding: wb_valid_o, wb_addr_o and wb_data_o form the forwarding bus. A consumer reading the same register in cycle N+1 must bypass from them.
- ALU latency: exactly 1 cycle to wb_*, always.
- Load latency:
  - 1 cycle when cut-through.
  - Otherwise 1 cycle after the first cycle in which it is FIFO head and the ALU is idle or writing x0.
- Starvation is allowed by design: continuous ALU traffic stalls loads indefinitely. Once the FIFO fills, load_ready_o stays low.
- Reset values:
  - wb_valid_o=0, wb_addr_o=0, wb_data_o=0.
  - FIFO empty, pointers 0, lq_count_o=0, pending_o=0.
  - load_ready_o=0 while reset is high.
- Reset asserted mid-operation discards all queued loads and any in-flight wb_* value. The first post-reset cycle has load_ready_o=1.

## Test plan
- ALU only: alu x5=0x1234 in cycle 1 → cycle 2: wb_valid_o=1, wb_addr_o=5, wb_data_o=0x1234. Cycle 3 with no input → wb_addr_o=0, wb_data_o=0, wb_valid_o=0.
- Cut-through: FIFO empty, ALU idle, load x7=0xAAAA offered → load_ready_o=1, nothing enqueued, next cycle wb x7=0xAAAA, lq_count_o stays 0.
- Buffering and backpressure: ALU writes x1..x4 over 4 consecutive cycles while loads x8=0x8, x9=0x9, x10=0x10 are offered.
  - x8 and x9 are enqueued; pending_o bits 8 and 9 are set; lq_count_o=2.
  - load_ready_o=0 holds x10.
  - After the ALU stops: wb writes x8, then x9, then x10, in order.
- x0 handling:
  - ALU x0=0xFFFF with FIFO head x3 → wb writes x3 that cycle.
  - Load x0 handshakes with no write and no enqueue.
- Simultaneous enqueue/dequeue: FIFO holds 1 entry, ALU idle, new load offered → head written, new load enqueued, lq_count_o stays 1. Pointer wrap is checked over 6 iterations.
- Reset mid-run: FIFO full, ALU active, reset for 1 cycle → all outputs 0, lq_count_o=0, pending_o=0. The next cycle has load_ready_o=1 and no stale write appears.

Source files
------------

// File: rtl/adr_writeback_if.sv
// Register-file write-side bundle: ALU result, load-result handshake, the write/forwarding
// port, and FIFO status. master drives results, slave is the write-back block.
interface adr_writeback_if #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned LQ_DEPTH     = 2
);
  localparam int unsigned CntW = $clog2(LQ_DEPTH) + 1;

  logic                    alu_valid_i;
  logic [REG_ADDR_LEN-1:0] alu_rd_i;
  logic [XLEN-1:0]         alu_data_i;
  logic                    load_valid_i;
  logic                    load_ready_o;
  logic [REG_ADDR_LEN-1:0] load_rd_i;
  logic [XLEN-1:0]         load_data_i;
  logic                    wb_valid_o;
  logic [REG_ADDR_LEN-1:0] wb_addr_o;
  logic [XLEN-1:0]         wb_data_o;
  logic [31:0]             pending_o;
  logic [CntW-1:0]         lq_count_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i, load_valid_i, load_rd_i, load_data_i,
    input  load_ready_o, wb_valid_o, wb_addr_o, wb_data_o, pending_o, lq_count_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i, load_valid_i, load_rd_i, load_data_i,
    output load_ready_o, wb_valid_o, wb_addr_o, wb_data_o, pending_o, lq_count_o
  );
endinterface

// File: rtl/adr_writeback.sv
// Register-file write-port driver: ALU results take priority, load results are buffered in a
// small circular FIFO or cut through when it is empty. Writes to x0 never reach the port.
module adr_writeback #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned LQ_DEPTH     = 2
) (
  input logic            clk,
  input logic            reset,
  adr_writeback_if.slave bus
);
  localparam int unsigned PtrW = $clog2(LQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [REG_ADDR_LEN-1:0] lq_rd_q   [LQ_DEPTH];
  logic [XLEN-1:0]         lq_data_q [LQ_DEPTH];
  logic [PtrW-1:0]         rptr_q, wptr_q;
  logic [CntW-1:0]         count_q;

  logic                    wb_valid_q, wb_valid_d;
  logic [REG_ADDR_LEN-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d;

  logic load_ready, load_fire, lq_empty;
  logic alu_sel, head_sel, cut_sel, enq, deq;
  logic [31:0]     pending;
  logic [PtrW-1:0] slot_off;

  // Ready looks only at the registered count; a same-cycle dequeue does not free a slot.
  assign lq_empty   = (count_q == '0);
  assign load_ready = (count_q < CntW'(LQ_DEPTH)) && !reset;
  assign load_fire  = bus.load_valid_i && load_ready;

  assign alu_sel  = bus.alu_valid_i && (bus.alu_rd_i != '0);
  assign head_sel = !alu_sel && !lq_empty;
  assign cut_sel  = !alu_sel && lq_empty && load_fire && (bus.load_rd_i != '0);
  assign enq      = load_fire && (bus.load_rd_i != '0) && !cut_sel;
  assign deq      = head_sel;

  always_comb begin
    wb_valid_d = 1'b0;
    wb_addr_d  = '0;
    wb_data_d  = '0;
    if (alu_sel) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = bus.alu_rd_i;
      wb_data_d  = bus.alu_data_i;
    end else if (head_sel) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = lq_rd_q[rptr_q];
      wb_data_d  = lq_data_q[rptr_q];
    end else if (cut_sel) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = bus.load_rd_i;
      wb_data_d  = bus.load_data_i;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending  = '0;
    slot_off = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      slot_off = PtrW'(i) - rptr_q;
      if ({1'b0, slot_off} < count_q) begin
        pending[lq_rd_q[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      if (enq) wptr_q <= wptr_q + PtrW'(1);
      if (deq) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(enq) - CntW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      lq_rd_q[wptr_q]   <= bus.load_rd_i;
      lq_data_q[wptr_q] <= bus.load_data_i;
    end
  end

  assign bus.load_ready_o = load_ready;
  assign bus.wb_valid_o   = wb_valid_q;
  assign bus.wb_addr_o    = wb_addr_q;
  assign bus.wb_data_o    = wb_data_q;
  assign bus.pending_o    = pending;
  assign bus.lq_count_o   = count_q;
endmodule
